// File: rtl/alg_amba_vip_base_vldrdy_downsize_if.sv
// Valid/ready bundle for the width downsizer: one wide input channel and one
// narrow output channel. The slave modport is the downsizer's view; the master
// modport is the view of whatever feeds wide beats and consumes narrow ones.
interface alg_amba_vip_base_vldrdy_downsize_if #(
  parameter int RATIO     = 2,
  parameter int OUT_WIDTH = 32
) ();
  localparam int NW = $clog2(RATIO);

  logic                       in_valid;
  logic [RATIO*OUT_WIDTH-1:0] in_data;
  logic [NW-1:0]              in_nslc_m1;
  logic                       in_last;
  logic                       in_ready;

  logic                       out_valid;
  logic [OUT_WIDTH-1:0]       out_data;
  logic                       out_last;
  logic                       out_ready;

  modport slave (
    input  in_valid, in_data, in_nslc_m1, in_last,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_nslc_m1, in_last,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/alg_amba_vip_base_vldrdy_downsize.sv
// Valid/ready width downsizer. A wide beat of RATIO slices is captured into a
// holding register and replayed as 1..RATIO narrow beats, one per cycle while
// the consumer is ready. The last slice of a beat can overlap with accepting
// the next wide beat, so a steady stream has no bubbles. All narrow-side
// outputs come straight from registers; the only combinational path between
// the two sides is out_ready -> in_ready.
module alg_amba_vip_base_vldrdy_downsize #(
  parameter int RATIO     = 2,
  parameter int OUT_WIDTH = 32,
  parameter int LSB_FIRST = 1
) (
  input  logic clk,
  input  logic rstn,
  alg_amba_vip_base_vldrdy_downsize_if.slave bus,
  output logic busy
);
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] MAX_IDX = CW'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [CW-1:0]                     hold_nslc_m1_q, hold_nslc_m1_d;
  logic                              hold_last_q, hold_last_d;
  logic [CW-1:0]                     cnt_q, cnt_d;

  logic          hold_valid;
  logic          slice_done;
  logic          beat_done;
  logic          in_fire;
  logic [CW-1:0] nslc_clamped;
  logic [CW-1:0] idx;

  assign hold_valid = (state_q == SER);

  // Slice-count clamp only exists when the count field can encode values past
  // RATIO-1 (non-power-of-two RATIO); otherwise the field is used as is.
  if (RATIO < (1 << CW)) begin : g_clamp
    assign nslc_clamped = (bus.in_nslc_m1 > MAX_IDX) ? MAX_IDX : bus.in_nslc_m1;
  end else begin : g_no_clamp
    assign nslc_clamped = bus.in_nslc_m1;
  end

  // Slice order: counter position maps to the low slice first, or mirrored.
  if (LSB_FIRST != 0) begin : g_lsb_first
    assign idx = cnt_q;
  end else begin : g_msb_first
    assign idx = MAX_IDX - cnt_q;
  end

  assign slice_done = hold_valid && bus.out_ready;
  assign beat_done  = slice_done && (cnt_q == hold_nslc_m1_q);

  // Ready is held low while reset is asserted so nothing is offered as accepted.
  assign bus.in_ready = rstn && (!hold_valid || beat_done);
  assign in_fire      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = hold_valid;
  assign bus.out_data  = hold_data_q[idx];
  assign bus.out_last  = hold_valid && hold_last_q && (cnt_q == hold_nslc_m1_q);
  assign busy          = hold_valid;

  // Next-state: capture, advance the slice counter, reload or drain.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d        = state_q;
    hold_data_d    = hold_data_q;
    hold_nslc_m1_d = hold_nslc_m1_q;
    hold_last_d    = hold_last_q;
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          hold_data_d    = bus.in_data;
          hold_nslc_m1_d = nslc_clamped;
          hold_last_d    = bus.in_last;
          cnt_d          = '0;
          state_d        = SER;
        end
      end
      SER: begin
        if (beat_done) begin
          cnt_d = '0;
          if (bus.in_valid) begin
            hold_data_d    = bus.in_data;
            hold_nslc_m1_d = nslc_clamped;
            hold_last_d    = bus.in_last;
          end else begin
            state_d = IDLE;
          end
        end else if (slice_done) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    if (!rstn) begin
      state_q        <= IDLE;
      // NOTE: the data holding register is reset as well, because out_data is
      // required to read zero while in reset and it is a wide mux of this word.
      hold_data_q    <= '0;
      hold_nslc_m1_q <= '0;
      hold_last_q    <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      hold_data_q    <= hold_data_d;
      hold_nslc_m1_q <= hold_nslc_m1_d;
      hold_last_q    <= hold_last_d;
      cnt_q          <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alg_amba_vip_base_vldrdy_downsize.sv
// Bench for the width downsizer. Three instances cover LSB-first RATIO=4,
// MSB-first RATIO=4 and LSB-first RATIO=3 (clamp case); one is selected at a
// time. A queue of expected narrow beats, built from each accepted wide beat,
// predicts out_valid/out_data/out_last/busy/in_ready every cycle.
module tb_alg_amba_vip_base_vldrdy_downsize;
  logic clk;
  logic rstn;

  logic [1:0]  sel;
  logic        drv_valid;
  logic [31:0] drv_data;
  logic [1:0]  drv_nslc;
  logic        drv_last;
  logic        drv_oready;

  logic        o_in_ready;
  logic        o_out_valid;
  logic [7:0]  o_out_data;
  logic        o_out_last;
  logic        o_busy;

  logic busy0, busy1, busy2;

  alg_amba_vip_base_vldrdy_downsize_if #(.RATIO(4), .OUT_WIDTH(8)) if0 ();
  alg_amba_vip_base_vldrdy_downsize_if #(.RATIO(4), .OUT_WIDTH(8)) if1 ();
  alg_amba_vip_base_vldrdy_downsize_if #(.RATIO(3), .OUT_WIDTH(8)) if2 ();

  alg_amba_vip_base_vldrdy_downsize #(.RATIO(4), .OUT_WIDTH(8), .LSB_FIRST(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .bus(if0), .busy(busy0));
  alg_amba_vip_base_vldrdy_downsize #(.RATIO(4), .OUT_WIDTH(8), .LSB_FIRST(0)) u_dut1 (
    .clk(clk), .rstn(rstn), .bus(if1), .busy(busy1));
  alg_amba_vip_base_vldrdy_downsize #(.RATIO(3), .OUT_WIDTH(8), .LSB_FIRST(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .bus(if2), .busy(busy2));

  assign if0.in_valid   = drv_valid && (sel == 2'd0);
  assign if0.in_data    = drv_data;
  assign if0.in_nslc_m1 = drv_nslc;
  assign if0.in_last    = drv_last;
  assign if0.out_ready  = drv_oready && (sel == 2'd0);

  assign if1.in_valid   = drv_valid && (sel == 2'd1);
  assign if1.in_data    = drv_data;
  assign if1.in_nslc_m1 = drv_nslc;
  assign if1.in_last    = drv_last;
  assign if1.out_ready  = drv_oready && (sel == 2'd1);

  assign if2.in_valid   = drv_valid && (sel == 2'd2);
  assign if2.in_data    = drv_data[23:0];
  assign if2.in_nslc_m1 = drv_nslc;
  assign if2.in_last    = drv_last;
  assign if2.out_ready  = drv_oready && (sel == 2'd2);

  always_comb begin
    o_in_ready  = if0.in_ready;
    o_out_valid = if0.out_valid;
    o_out_data  = if0.out_data;
    o_out_last  = if0.out_last;
    o_busy      = busy0;
    case (sel)
      2'd1: begin
        o_in_ready = if1.in_ready; o_out_valid = if1.out_valid;
        o_out_data = if1.out_data; o_out_last  = if1.out_last; o_busy = busy1;
      end
      2'd2: begin
        o_in_ready = if2.in_ready; o_out_valid = if2.out_valid;
        o_out_data = if2.out_data; o_out_last  = if2.out_last; o_busy = busy2;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } slice_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       rdy;
    int         cyc;
  } obs_t;

  slice_t exp_q[$];
  obs_t   log_q[$];
  int     checks;
  int     errors;
  int     cyc;
  int     m_ratio;
  int     m_lsb;
  bit     last_acc;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sel_cfg(int s);
    sel     = 2'(s);
    m_ratio = (s == 2) ? 3 : 4;
    m_lsb   = (s == 1) ? 0 : 1;
  endtask

  // Expand one accepted wide beat into the narrow beats it must produce.
  task automatic push_beat(logic [31:0] d, logic [1:0] n, logic l);
    int     cnt;
    int     idx;
    slice_t s;
    cnt = (int'(n) > m_ratio - 1) ? m_ratio : int'(n) + 1;
    for (int i = 0; i < cnt; i++) begin
      idx    = (m_lsb != 0) ? i : m_ratio - 1 - i;
      s.data = 8'(d >> (8 * idx));
      s.last = l && (i == cnt - 1);
      exp_q.push_back(s);
    end
  endtask

  // One clock: compare outputs with the model, then account for handshakes.
  task automatic tick();
    bit   exp_rdy;
    bit   acc_in;
    bit   acc_out;
    obs_t o;
    #1;
    exp_rdy = rstn && ((exp_q.size() == 0) || (exp_q.size() == 1 && drv_oready));
    check("out_valid", o_out_valid, exp_q.size() != 0);
    check("busy", o_busy, exp_q.size() != 0);
    check("in_ready", o_in_ready, exp_rdy);
    if (exp_q.size() != 0) begin
      check("out_data", o_out_data, exp_q[0].data);
      check("out_last", o_out_last, exp_q[0].last);
    end
    acc_in  = rstn && drv_valid && exp_rdy;
    acc_out = rstn && (exp_q.size() != 0) && drv_oready;
    if (acc_out) begin
      o.data = o_out_data; o.last = o_out_last; o.rdy = o_in_ready; o.cyc = cyc;
      log_q.push_back(o);
      void'(exp_q.pop_front());
    end
    if (acc_in) push_beat(drv_data, drv_nslc, drv_last);
    if (!rstn) exp_q.delete();
    last_acc = acc_in;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(logic [31:0] d, logic [1:0] n, logic l);
    int k;
    k = 0;
    drv_valid = 1'b1; drv_data = d; drv_nslc = n; drv_last = l;
    do begin
      tick();
      k++;
    end while (!last_acc && k < 50);
    check("send_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    drv_valid = 1'b0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  // Compare the logged narrow beats with a directed sequence (first byte in
  // the low bits of exp_bytes) and require them on consecutive cycles.
  task automatic check_log(string tag, int n, logic [63:0] exp_bytes, logic [7:0] exp_last);
    check({tag, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), log_q[i].data, exp_bytes[8*i +: 8]);
      check($sformatf("%s_last%0d", tag, i), log_q[i].last, exp_last[i]);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), log_q[i].cyc - log_q[i-1].cyc, 1);
    end
  endtask

  task automatic rand_run(int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (!drv_valid && $urandom_range(0, 2) != 0) begin
        drv_valid = 1'b1;
        drv_data  = $urandom;
        drv_nslc  = 2'($urandom_range(0, 3));
        drv_last  = 1'($urandom_range(0, 1));
      end
      drv_oready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) drv_valid = 1'b0;
    end
    drv_oready = 1'b1;
    drain();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_acc = 0;
    rstn = 1'b0; drv_valid = 1'b0; drv_data = '0; drv_nslc = '0; drv_last = 1'b0;
    drv_oready = 1'b1;
    sel_cfg(0);
    repeat (2) @(negedge clk);

    // Reset held with in_valid high: nothing is accepted or presented.
    drv_valid = 1'b1; drv_data = 32'h1234_5678; drv_nslc = 2'd3;
    repeat (3) begin
      #1;
      check("t1_out_valid", o_out_valid, 0);
      check("t1_busy", o_busy, 0);
      check("t1_out_data", o_out_data, 0);
      tick();
    end
    drv_valid = 1'b0;
    rstn = 1'b1;
    #1;
    check("t1_in_ready_after_release", o_in_ready, 1);
    tick();

    // Full beat, LSB first.
    log_q.delete();
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    drain();
    check_log("t2", 4, 64'hDDCCBBAA, 8'b1000);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      check($sformatf("t2_in_ready%0d", i), log_q[i].rdy, (i == 3));

    // Partial beat followed back-to-back by another.
    log_q.delete();
    send(32'h44332211, 2'd1, 1'b0);
    send(32'h88776655, 2'd2, 1'b1);
    drain();
    check_log("t3", 5, 64'h77_66_55_22_11, 8'b10000);

    // Backpressure while BB is presented.
    log_q.delete();
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    drv_valid = 1'b0;
    tick();
    drv_oready = 1'b0;
    repeat (5) begin
      #1;
      check("t4_stall_data", o_out_data, 8'hBB);
      check("t4_stall_valid", o_out_valid, 1);
      tick();
    end
    drv_oready = 1'b1;
    drain();
    check("t4_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      check($sformatf("t4_data%0d", i), log_q[i].data, 8'(32'hDDCCBBAA >> (8 * i)));

    // MSB first.
    sel_cfg(1);
    log_q.delete();
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    drain();
    check_log("t5_msb", 4, 64'hAABBCCDD, 8'b1000);

    // RATIO=3 with a slice count that must clamp to three slices.
    sel_cfg(2);
    log_q.delete();
    send(32'h00CCBBAA, 2'd3, 1'b1);
    drain();
    check_log("t5_clamp", 3, 64'hCCBBAA, 8'b100);

    // Reset in the middle of a beat.
    sel_cfg(0);
    log_q.delete();
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    drv_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    #1;
    check("t6_flush_valid", o_out_valid, 0);
    check("t6_flush_busy", o_busy, 0);
    tick();
    rstn = 1'b1;
    log_q.delete();
    send(32'h87654321, 2'd3, 1'b1);
    drain();
    check_log("t6_after", 4, 64'h87654321, 8'b1000);

    // Random traffic on each configuration.
    for (int s = 0; s < 3; s++) begin
      sel_cfg(s);
      rand_run(400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
